// File: rtl/modulus_arb_pkg.sv
// Shared state encoding and default parameters for the modulus stream arbiter.
package modulus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int DEF_W           = 16;
  localparam int DEF_N           = 4;
  localparam int DEF_FRAME_LEN   = 1024;
  localparam int DEF_TIMEOUT_CYC = 4096;

  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/modulus_arb_skid.sv
// Two-entry register buffer with ping-pong write/read pointers; full when both
// slots hold data, so the write slot is always free whenever in_ready is high.
module modulus_arb_skid #(
  parameter int DW = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic [1:0]    vld_q, vld_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic          push, pop;

  assign in_ready  = ~(&vld_q);
  assign out_valid = vld_q[rd_ptr_q];
  assign out_data  = mem_q[rd_ptr_q];

  always_comb begin
    push     = in_valid & in_ready;
    pop      = out_valid & out_ready;
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ~rd_ptr_q;
    end
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = ~wr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      vld_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/modulus_stream_arb.sv
// Round-robin frame arbiter: N sample streams merged into one, FRAME_LEN beats per grant.
// Define MODULUS_ARB_TIMEOUT_EN to abort frames whose source stalls for TIMEOUT_CYC cycles.
//
// state | meaning
// IDLE  | pick next requester round-robin, no beats accepted
// XFER  | stream beats from the granted channel until last beat or abort
module modulus_stream_arb
  import modulus_arb_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int N           = DEF_N,
  parameter int FRAME_LEN   = DEF_FRAME_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int CW         = chan_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   s_valid,
  input  logic [N*W-1:0] s_data,
  output logic [N-1:0]   s_ready,
  output logic           m_valid,
  output logic [W-1:0]   m_data,
  output logic [CW-1:0]  m_chan,
  output logic           m_last,
  input  logic           m_ready,
  output logic           busy,
  output logic           frame_done,
  output logic           timeout
);

  localparam int CNTW = $clog2(FRAME_LEN);
  localparam int BW   = W + CW + 1;

  arb_state_e      state_q, state_d;
  logic [CW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   last_grant_q, last_grant_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   rr_pick;
  int              rr_idx;
  logic            rr_found;
  logic            buf_in_ready, src_valid, accept, last_beat, abort;
  logic [W-1:0]    sel_data;
  logic [BW-1:0]   buf_out;

  always_comb begin
    rr_pick  = last_grant_q;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      rr_idx = (int'(last_grant_q) + k) % N;
      if (!rr_found && s_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = CW'(rr_idx);
      end
    end
  end

  always_comb begin
    sel_data  = s_data[int'(grant_q)*W +: W];
    src_valid = (state_q == XFER) & s_valid[grant_q];
    accept    = src_valid & buf_in_ready;
    last_beat = (cnt_q == CNTW'(FRAME_LEN - 1));
    s_ready   = '0;
    if ((state_q == XFER) && buf_in_ready) s_ready[grant_q] = 1'b1;
  end

`ifdef MODULUS_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC + 1);
  logic [SW-1:0] stall_q, stall_d;

  // Abort fires on the stalled cycle that would bring the count to TIMEOUT_CYC.
  always_comb begin
    stall_d = stall_q;
    abort   = 1'b0;
    if (state_q != XFER) begin
      stall_d = '0;
    end else if (accept) begin
      stall_d = '0;
    end else if (!s_valid[grant_q]) begin
      if (stall_q == SW'(TIMEOUT_CYC - 1)) begin
        abort   = 1'b1;
        stall_d = '0;
      end else begin
        stall_d = stall_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d = rr_pick;
          state_d = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          if (last_beat) begin
            cnt_d        = '0;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end else if (abort) begin
          cnt_d        = '0;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CW'(N - 1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  modulus_arb_skid #(.DW(BW)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (src_valid),
    .in_ready (buf_in_ready),
    .in_data  ({grant_q, last_beat, sel_data}),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data (buf_out)
  );

  assign {m_chan, m_last, m_data} = buf_out;
  assign busy       = (state_q == XFER);
  assign frame_done = accept & last_beat;
  assign timeout    = abort;

endmodule

// File: tb/tb_modulus_stream_arb.sv
// Directed bench for modulus_stream_arb (N=4, W=16, FRAME_LEN=4, TIMEOUT_CYC=8).
module tb_modulus_stream_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  s_valid, s_ready;
  logic [63:0] s_data;
  logic        m_valid, m_ready, m_last, busy, frame_done, timeout;
  logic [15:0] m_data;
  logic [1:0]  m_chan;

  int          rem [4];
  logic [15:0] dat [4];
  logic [18:0] beats [$];
  int          stamps [$];
  int          vectors = 0, miscompares = 0;
  int          fd_cnt = 0, to_cnt = 0, cyc_n = 0, fd_base;
  logic        tog;
  int          fch [5] = '{0, 1, 2, 3, 0};
  logic [15:0] fbase [5] = '{16'h0A00, 16'h1B00, 16'h0014, 16'h3C02, 16'h0A04};

  modulus_stream_arb #(.W(16), .N(4), .FRAME_LEN(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_chan(m_chan), .m_last(m_last),
    .m_ready(m_ready), .busy(busy), .frame_done(frame_done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      s_valid[i]         = (rem[i] > 0);
      s_data[i*16 +: 16] = dat[i];
    end
  endtask

  // Sample at the falling edge, then advance sources whose beat was taken.
  task automatic cyc();
    logic [3:0] acc;
    @(negedge clk);
    if (m_valid && m_ready) begin
      beats.push_back({m_chan, m_last, m_data});
      stamps.push_back(cyc_n);
    end
    if (frame_done) fd_cnt++;
    if (timeout) to_cnt++;
    acc = s_valid & s_ready;
    @(posedge clk);
    #1;
    cyc_n++;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        dat[i] = dat[i] + 16'd1;
        if (rem[i] > 0) rem[i]--;
      end
    end
    if (tog) m_ready = ~m_ready;
    drive();
    #1;
  endtask

  task automatic expect_beat(input string tag, input logic [1:0] ch, input logic lst,
                             input logic [15:0] d);
    logic [18:0] got;
    got = (beats.size() > 0) ? beats.pop_front() : '1;
    chk(tag, got, {ch, lst, d});
  endtask

  initial begin
    rst_n   = 1'b0;
    m_ready = 1'b1;
    tog     = 1'b0;
    rem     = '{0, 0, 0, 0};
    dat     = '{16'h0A00, 16'h1B00, 16'h0010, 16'h3C00};
    drive();
    repeat (3) cyc();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_chan", m_chan, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_timeout", timeout, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rel_busy", busy, 0);
    repeat (2) cyc();

    // Single requester ch2: grant cycle, then one cycle of latency.
    rem[2] = 4; drive(); #1;
    chk("s1_c0_m_valid", m_valid, 0);
    chk("s1_c0_s_ready", s_ready, 4'b0000);
    cyc();
    chk("s1_c1_s_ready", s_ready, 4'b0100);
    chk("s1_c1_busy", busy, 1);
    chk("s1_c1_m_valid", m_valid, 0);
    cyc();
    chk("s1_c2_m_valid", m_valid, 1);
    chk("s1_c2_m_data", m_data, 16'h0010);
    chk("s1_c2_m_chan", m_chan, 2);
    cyc(); cyc();
    chk("s1_c4_frame_done", frame_done, 1);
    chk("s1_c4_m_data", m_data, 16'h0012);
    cyc();
    chk("s1_c5_m_data", m_data, 16'h0013);
    chk("s1_c5_m_last", m_last, 1);
    chk("s1_c5_busy", busy, 0);
    chk("s1_c5_frame_done", frame_done, 0);
    repeat (3) cyc();
    chk("s1_beats", beats.size(), 4);
    for (int b = 0; b < 4; b++)
      expect_beat($sformatf("s1_beat%0d", b), 2'd2, (b == 3), 16'h0010 + 16'(b));
    chk("s1_fd_cnt", fd_cnt, 1);
    stamps.delete();

    // ch3 frame interrupted by reset after two accepted beats.
    rem[3] = 100; drive(); #1;
    repeat (3) cyc();
    chk("rm_pre_m_data", m_data, 16'h3C01);
    rst_n = 1'b0; #1;
    chk("rm_m_valid", m_valid, 0);
    chk("rm_m_data", m_data, 0);
    chk("rm_s_ready", s_ready, 0);
    chk("rm_busy", busy, 0);
    chk("rm_m_last", m_last, 0);
    repeat (2) cyc();
    chk("rm_beats", beats.size(), 1);
    expect_beat("rm_beat0", 2'd3, 1'b0, 16'h3C00);
    stamps.delete();
    fd_base = fd_cnt;

    // All four channels requesting: 0,1,2,3,0 with one idle cycle between frames.
    rem = '{8, 4, 4, 4}; drive();
    rst_n = 1'b1; #1;
    chk("rr_rel_busy", busy, 0);
    cyc();
    chk("rr_first_grant", s_ready, 4'b0001);
    repeat (30) cyc();
    chk("rr_beats", beats.size(), 20);
    if (stamps.size() >= 20) begin
      chk("rr_gap", stamps[4] - stamps[0], 5);
      chk("rr_span", stamps[19] - stamps[0], 23);
    end else begin
      chk("rr_stamps", stamps.size(), 20);
    end
    for (int f = 0; f < 5; f++)
      for (int b = 0; b < 4; b++)
        expect_beat($sformatf("rr_f%0d_b%0d", f, b), 2'(fch[f]), (b == 3),
                    fbase[f] + 16'(b));
    chk("rr_fd_cnt", fd_cnt - fd_base, 5);
    stamps.delete();

    // m_ready toggling: buffer fills, s_ready drops, held data stays put.
    m_ready = 1'b0; tog = 1'b1; rem[1] = 4; drive(); #1;
    cyc();
    chk("bp_c1_busy", busy, 1);
    chk("bp_c1_s_ready", s_ready, 4'b0010);
    cyc();
    chk("bp_c2_m_valid", m_valid, 1);
    chk("bp_c2_m_data", m_data, 16'h1B04);
    cyc();
    chk("bp_c3_m_data", m_data, 16'h1B04);
    chk("bp_c3_s_ready", s_ready, 4'b0000);
    cyc(); cyc();
    chk("bp_c5_s_ready", s_ready, 4'b0000);
    cyc();
    chk("bp_c6_frame_done", frame_done, 1);
    tog = 1'b0; m_ready = 1'b1;
    repeat (5) cyc();
    chk("bp_beats", beats.size(), 4);
    for (int b = 0; b < 4; b++)
      expect_beat($sformatf("bp_beat%0d", b), 2'd1, (b == 3), 16'h1B04 + 16'(b));
    stamps.delete();

    // ch1 sends two beats then stalls; ch2 waits behind it.
    rem[1] = 2; drive(); #1;
    cyc();
    rem[2] = 4; drive(); #1;
    chk("st_c1_s_ready", s_ready, 4'b0010);
    repeat (4) cyc();
    chk("st_c5_s_ready", s_ready, 4'b0010);
    chk("st_c5_busy", busy, 1);
    repeat (4) cyc();
    chk("st_c9_timeout", timeout, 0);
    cyc();
`ifdef MODULUS_ARB_TIMEOUT_EN
    chk("st_c10_timeout", timeout, 1);
    cyc();
    chk("st_c11_busy", busy, 0);
    cyc();
    chk("st_c12_s_ready", s_ready, 4'b0100);
    repeat (8) cyc();
    chk("st_beats", beats.size(), 6);
    expect_beat("st_beat0", 2'd1, 1'b0, 16'h1B08);
    expect_beat("st_beat1", 2'd1, 1'b0, 16'h1B09);
    chk("st_to_cnt", to_cnt, 1);
`else
    chk("st_c10_timeout", timeout, 0);
    chk("st_c10_busy", busy, 1);
    cyc(); cyc();
    rem[1] = 2; drive(); #1;
    chk("st_c12_busy", busy, 1);
    chk("st_c12_s_ready", s_ready, 4'b0010);
    cyc();
    chk("st_c13_frame_done", frame_done, 1);
    cyc();
    chk("st_c14_busy", busy, 0);
    cyc();
    chk("st_c15_s_ready", s_ready, 4'b0100);
    repeat (8) cyc();
    chk("st_beats", beats.size(), 8);
    for (int b = 0; b < 4; b++)
      expect_beat($sformatf("st_beat%0d", b), 2'd1, (b == 3), 16'h1B08 + 16'(b));
    chk("st_to_cnt", to_cnt, 0);
`endif
    for (int b = 0; b < 4; b++)
      expect_beat($sformatf("st_ch2_beat%0d", b), 2'd2, (b == 3), 16'h0018 + 16'(b));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
